// File: rtl/mux_nx1_seq.sv
// N-input, WIDTH-bit registered multiplexer with a valid/ready output slot and auto-scan select.
// Optional MUX_PARITY_EN adds a registered even-parity bit (result_par) alongside result.
module mux_nx1_seq #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] d,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_load,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic               result_par
`endif
);

    localparam int             SLOTS   = 2 ** SEL_W;
    localparam logic [SEL_W:0] N_EXT   = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

    generate
        if (SLOTS < N) begin : g_bad_sel_w
            $error("mux_nx1_seq: SEL_W too narrow for N channels");
        end
    endgenerate

    // Channel table is padded to a power of two so sel_cur indexes it at its exact width.
    logic [WIDTH-1:0] chan [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_chan
            if (gi < N) begin : g_live
                assign chan[gi] = d[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] sel_data;
    logic             slot_free;
    logic             capture;
    logic             sel_in_ok;

    logic [WIDTH-1:0] result_reg, result_next;
    logic             out_valid_reg, out_valid_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             sel_err_reg, sel_err_next;

    assign sel_data  = chan[sel_reg];
    assign slot_free = !out_valid_reg || out_ready;
    assign capture   = en && slot_free;
    assign sel_in_ok = ({1'b0, sel_in} < N_EXT);

    always_comb begin
        result_next    = result_reg;
        out_valid_next = out_valid_reg;
        if (capture) begin
            result_next    = sel_data;
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // A load always beats a scan advance; the capture on that edge still uses the old select.
    always_comb begin
        sel_next     = sel_reg;
        sel_err_next = sel_err_reg;
        if (sel_load) begin
            if (sel_in_ok) begin
                sel_next = sel_in;
            end else begin
                sel_err_next = 1'b1;
            end
        end else if (mode && capture) begin
            sel_next = (sel_reg == LAST_SEL) ? '0 : sel_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            sel_reg       <= '0;
            sel_err_reg   <= 1'b0;
        end else begin
            result_reg    <= result_next;
            out_valid_reg <= out_valid_next;
            sel_reg       <= sel_next;
            sel_err_reg   <= sel_err_next;
        end
    end

`ifdef MUX_PARITY_EN
    logic result_par_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_par_reg <= 1'b0;
        end else if (capture) begin
            result_par_reg <= ^sel_data;
        end
    end

    assign result_par = result_par_reg;
`endif

    assign result    = result_reg;
    assign out_valid = out_valid_reg;
    assign sel_cur   = sel_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Directed bench for mux_nx1_seq: a 4-channel instance driven through a scoreboard model,
// plus a 3-channel instance for out-of-range select loads. Define MUX_PARITY_EN to check result_par.
module tb_mux_nx1_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d = 32'h0;
    logic        en = 1'b0, mode = 1'b0, sel_load = 1'b0, out_ready = 1'b0;
    logic [1:0]  sel_in = 2'd0;
    logic        out_valid, sel_err;
    logic [7:0]  result;
    logic [1:0]  sel_cur;

    logic        en3 = 1'b0, mode3 = 1'b0, sel_load3 = 1'b0, out_ready3 = 1'b1;
    logic [1:0]  sel_in3 = 2'd0;
    logic        out_valid3, sel_err3;
    logic [7:0]  result3;
    logic [1:0]  sel_cur3;

`ifdef MUX_PARITY_EN
    logic result_par, result_par3;
`endif

    always #5 clk = ~clk;

    mux_nx1_seq #(.WIDTH(8), .N(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load), .out_ready(out_ready),
        .out_valid(out_valid), .result(result), .sel_cur(sel_cur), .sel_err(sel_err)
`ifdef MUX_PARITY_EN
        , .result_par(result_par)
`endif
    );

    mux_nx1_seq #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .d(d[23:0]), .en(en3), .mode(mode3),
        .sel_in(sel_in3), .sel_load(sel_load3), .out_ready(out_ready3),
        .out_valid(out_valid3), .result(result3), .sel_cur(sel_cur3), .sel_err(sel_err3)
`ifdef MUX_PARITY_EN
        , .result_par(result_par3)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference state for the 4-channel instance
    logic [7:0] exp_q[$];
    logic [7:0] m_res = 8'h00;
    logic       m_valid = 1'b0;
    logic [1:0] m_sel = 2'd0;
    logic       m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chan_of(input logic [31:0] dv, input logic [1:0] s);
        logic [31:0] tmp;
        tmp = dv >> (8 * s);
        return tmp[7:0];
    endfunction

    // One clock: drive inputs, predict from the model, then check after the edge.
    task automatic cycle(input string tag, input logic e, input logic m, input logic ld,
                         input logic [1:0] si, input logic rdy);
        logic cap;
        logic [7:0] got;
        en = e; mode = m; sel_load = ld; sel_in = si; out_ready = rdy;
        cap = e && (!m_valid || rdy);
        if (cap) exp_q.push_back(chan_of(d, m_sel));
        if (ld) m_sel = si;
        else if (m && cap) m_sel = (m_sel == 2'd3) ? 2'd0 : m_sel + 2'd1;
        if (cap) m_valid = 1'b1;
        else if (m_valid && rdy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        if (cap) begin
            got = exp_q.pop_front();
            m_res = got;
        end
        check({tag, ".result"}, {24'h0, result}, {24'h0, m_res});
        check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, m_valid});
        check({tag, ".sel"}, {30'h0, sel_cur}, {30'h0, m_sel});
`ifdef MUX_PARITY_EN
        check({tag, ".par"}, {31'h0, result_par}, {31'h0, ^m_res});
`endif
        $display("[TB] %s en=%0b mode=%0b load=%0b sel_in=%0d rdy=%0b -> valid=%0b result=%02h sel=%0d",
                 tag, e, m, ld, si, rdy, out_valid, result, sel_cur);
    endtask

    task automatic idle_inputs();
        en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel_in = 2'd0; out_ready = 1'b0;
    endtask

    initial begin
        // Reset state, asserted from time zero
        #12;
        check("rst.result", {24'h0, result}, 32'h0);
        check("rst.valid", {31'h0, out_valid}, 32'h0);
        check("rst.sel", {30'h0, sel_cur}, 32'h0);
        check("rst.err", {31'h0, sel_err}, 32'h0);
        check("rst3.err", {31'h0, sel_err3}, 32'h0);
        rst_n = 1'b1;
        d = 32'h44332211;

        // Manual select: load 2, then every capture is channel 2
        cycle("load2", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) cycle("man", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        check("man.const", {24'h0, result}, 32'h33);

        // Auto-scan from channel 0 wraps 3 -> 0
        cycle("load0", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) cycle("scan", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        check("scan.wrap_res", {24'h0, result}, 32'h11);
        check("scan.wrap_sel", {30'h0, sel_cur}, 32'h1);

        // Backpressure: frozen for three cycles, then next channel with no loss
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        check("stall.res", {24'h0, result}, 32'h11);
        check("stall.sel", {30'h0, sel_cur}, 32'h1);
        cycle("resume", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        check("resume.res", {24'h0, result}, 32'h22);

        // Load on a scan-capture edge: sample from old select, load wins
        cycle("ldadv", 1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        check("ldadv.res", {24'h0, result}, 32'h33);
        check("ldadv.sel", {30'h0, sel_cur}, 32'h0);
        cycle("ldadv2", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        check("ldadv2.res", {24'h0, result}, 32'h11);

        // Drain keeps result, then parity words
        cycle("drain", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        check("drain.valid", {31'h0, out_valid}, 32'h0);
        d = 32'h44332207;
        cycle("par07.ld", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        cycle("par07", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle("par33.ld", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        cycle("par33", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle("hold.ld", 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);

        // Mid-transfer asynchronous reset, checked before any clock edge
        check("pre_rst.valid", {31'h0, out_valid}, 32'h1);
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        check("arst.result", {24'h0, result}, 32'h0);
        check("arst.valid", {31'h0, out_valid}, 32'h0);
        check("arst.sel", {30'h0, sel_cur}, 32'h0);
        check("arst.err", {31'h0, sel_err}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_res = 8'h00; m_valid = 1'b0; m_sel = 2'd0; m_err = 1'b0;
        $display("[TB] async reset released");

        // 3-channel instance: out-of-range load is rejected and sticky
        sel_load3 = 1'b1; sel_in3 = 2'd1;
        @(posedge clk); #1;
        check("n3.ld1.sel", {30'h0, sel_cur3}, 32'h1);
        check("n3.ld1.err", {31'h0, sel_err3}, 32'h0);
        $display("[TB] n3 load 1 -> sel=%0d err=%0b", sel_cur3, sel_err3);
        sel_in3 = 2'd3;
        @(posedge clk); #1;
        check("n3.bad.sel", {30'h0, sel_cur3}, 32'h1);
        check("n3.bad.err", {31'h0, sel_err3}, 32'h1);
        $display("[TB] n3 load 3 -> sel=%0d err=%0b", sel_cur3, sel_err3);
        sel_in3 = 2'd2;
        @(posedge clk); #1;
        check("n3.ld2.sel", {30'h0, sel_cur3}, 32'h2);
        check("n3.ld2.err", {31'h0, sel_err3}, 32'h1);
        $display("[TB] n3 load 2 -> sel=%0d err=%0b", sel_cur3, sel_err3);
        sel_load3 = 1'b0; en3 = 1'b1; mode3 = 1'b1;
        @(posedge clk); #1;
        check("n3.scan.res", {24'h0, result3}, 32'h33);
        check("n3.scan.wrap", {30'h0, sel_cur3}, 32'h0);
        $display("[TB] n3 scan -> result=%02h sel=%0d", result3, sel_cur3);
        en3 = 1'b0; mode3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
